outputc: RTL and testbench
==========================

Name: outputc

Overview:
- Transmit end of the router-to-router link. One instance per output physical channel.
- Accepts flits from the crossbar into per-VC output buffers and advertises per-VC ready/lock status back to the router's input channels, which consume it as irdy_N/ilck_N.
- Arbitrates round-robin among the VCs and drives odata/ovalid/ovch onto the link toward the downstream router's input channel, gated per VC by that channel's ordy.

Parameters:
ROUTERID, 0, router index; used only in assertion/debug messages
PCHID, 0, physical channel index; used only in assertion/debug messages
DEPTH, 4, entries per VC buffer; power of two, minimum 4

Ports:
clk  input  1  clock
rst_  input  1  reset, synchronous, active-high (asserted = 1, sampled on posedge clk)
idata  input  `DATAW+1  flit from crossbar
ivalid  input  1  flit valid from crossbar
ivch  input  `VCHW+1  target output VC of incoming flit
ordy  output  `VCH+1  per-VC "buffer can accept"; feeds irdy_N of input channels
olck  output  `VCH+1  per-VC "reserved by in-flight packet"; feeds ilck_N of input channels
odata  output  `DATAW+1  flit to link, registered
ovalid  output  1  link valid, registered
ovch  output  `VCHW+1  link VC id, registered
irdy  input  `VCH+1  downstream input channel's ordy, per VC
ovf  output  1  sticky error: write attempted into a full VC buffer

Behaviour:
- Clock and reset: one clock, clk. rst_ is synchronous and active-high. On a posedge with rst_=1, all state clears.
- Reset values:
  - counts, read pointers and write pointers = 0
  - lock bits = 0, so olck = 0
  - round-robin pointer = 0
  - odata = 0, ovalid = 0, ovch = 0, ovf = 0
  - ordy = all ones from the first cycle after reset (buffers empty)
  - Reset mid-packet discards buffered flits and lock state with no drain.
- Flit type: taken from idata[`TYPE_MSB:`TYPE_LSB].
  - ivalid with type `TYPE_NONE is ignored.
- Write:
  - Condition: ivalid && type != NONE.
  - Flit is written into VC ivch's buffer; count[ivch] increments unless the same VC pops in that cycle.
  - If count[ivch] == DEPTH and there is no same-cycle pop: flit is dropped, ovf sets and stays set until reset.
- ordy[v]:
  - Combinational: ordy[v] = (count[v] <= DEPTH-2), i.e. at least 2 free slots.
  - The 2-slot margin absorbs the one-cycle grant-to-flit latency of the input channel.
- olck[v] (registered):
  - Sets on write of a HEAD flit to VC v.
  - Clears on write of a TAIL flit to VC v.
  - HEADTAIL and BODY leave it unchanged.
  - HEAD written while olck[v]=1: lock stays set and an assertion fires (protocol violation).
- Eligibility: VC v is eligible when count[v] != 0 && irdy[v] == 1.
- Arbitration:
  - Round-robin starting at rr_ptr; picks the first eligible VC in cyclic order.
  - At most one pop per cycle.
  - On a pop of VC v: rr_ptr <= v+1, wrapping modulo `VCH+1. No pop leaves rr_ptr unchanged.
- Output stage:
  - Popped flit appears on odata next cycle with ovalid=1 and ovch=v.
  - With no pop: ovalid=0, odata=0, ovch holds its previous value.
  - Latency: ivalid-to-ovalid is 2 cycles minimum (write cycle, then pop cycle, then registered out) when the VC is empty and irdy=1.
  - Throughput: 1 flit/cycle across all VCs.
- Simultaneous push and pop on the same VC: count unchanged. The full-buffer check uses the post-pop occupancy, so a full VC that pops accepts the write.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- irdy drop: if irdy[v] drops while a flit is queued, nothing pops from v. The other VCs continue, with no head-of-line blocking across VCs.
- Ordering: flits within a VC leave in FIFO order. There is no ordering guarantee across VCs.

Decomposition:
- define.sv (shared): add `OUTBUF_DEPTH (default 4) and `OUTBUF_PTRW.
  - Existing `DATAW, `VCH, `VCHW, `TYPE_* and `TYPE_MSB/LSB are reused unchanged.
- Sub-module outc_vcbuf: a single-VC circular buffer. It carries the DEPTH parameter and provides:
  - push, pop, dout, count
  - ordy (2-slot margin)
  - lock tracking
  - per-instance overflow flag
- outputc:
  - instantiates `VCH+1 outc_vcbuf instances
  - holds the round-robin arbiter, output register, and ovf OR-reduction

Test Plan:
- Reset then idle: rst_=1 for 2 cycles, then 0 -> ordy=2'b11, olck=0, ovalid=0, odata=0, ovf=0.
- Single HEADTAIL on VC0 with irdy=2'b11 at cycle t -> odata equals that flit, ovch=0, ovalid=1 at t+2; olck[0] stays 0.
- 3-flit packet (HEAD, BODY, TAIL) on VC1 with irdy[1]=0 -> olck[1]=1 after HEAD; ordy[1]=0 once count=3 (DEPTH=4). Then raise irdy[1] -> 3 flits emitted in order on consecutive cycles; olck[1]=0 after TAIL write.
- Both VCs hold 2 flits, irdy=2'b11, rr_ptr=0 -> output VC order is 0,1,0,1. Then drop irdy[0] mid-stream -> only VC1 flits emitted.
- VC0 full (count=4) with irdy[0]=0 and a fifth write -> flit dropped, ovf=1 and held. Then assert rst_ -> ovf=0, counts=0.
- Mid-packet reset: HEAD written to VC0 (olck[0]=1), then rst_=1 for one cycle -> olck=0, ovalid=0 next cycle, and no stale flit is emitted afterward.

Source files
------------

// File: rtl/outputc_pkg.sv
// Shared link-format macros plus the outputc package: flit types, widths and VC helpers.
// Macros are guarded so an existing router-wide define set takes precedence.
`ifndef OUTPUTC_DEFINES_SV
`define OUTPUTC_DEFINES_SV
`define DATAW         31
`define VCH           1
`define VCHW          0
`define TYPE_MSB      31
`define TYPE_LSB      29
`define TYPE_NONE     3'd0
`define TYPE_HEAD     3'd1
`define TYPE_BODY     3'd2
`define TYPE_TAIL     3'd3
`define TYPE_HEADTAIL 3'd4
`define OUTBUF_DEPTH  4
`define OUTBUF_PTRW   2
`endif

package outputc_pkg;
  localparam int DW       = `DATAW + 1;
  localparam int NVC      = `VCH + 1;
  localparam int VCW      = `VCHW + 1;
  localparam int TYPE_MSB = `TYPE_MSB;
  localparam int TYPE_LSB = `TYPE_LSB;
  localparam int TW       = TYPE_MSB - TYPE_LSB + 1;

  typedef enum logic [TW-1:0] {
    FT_NONE     = `TYPE_NONE,
    FT_HEAD     = `TYPE_HEAD,
    FT_BODY     = `TYPE_BODY,
    FT_TAIL     = `TYPE_TAIL,
    FT_HEADTAIL = `TYPE_HEADTAIL
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [DW-1:0] d);
    return flit_type_e'(d[TYPE_MSB:TYPE_LSB]);
  endfunction

  // Cyclic successor of a VC id; NVC need not be a power of two.
  function automatic logic [VCW-1:0] vc_inc(input logic [VCW-1:0] v);
    return (int'(v) == NVC - 1) ? '0 : v + 1'b1;
  endfunction
endpackage

// File: rtl/outputc_vcbuf.sv
// Single-VC circular flit buffer with occupancy, 2-slot-margin ready, packet lock and sticky overflow.
// Read data is combinational from the read pointer; a full buffer accepts a write only when it pops that cycle.
module outc_vcbuf
  import outputc_pkg::*;
#(
  parameter int DEPTH = `OUTBUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [DW-1:0]           i_din,
  output logic [DW-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_rdy,
  output logic                    o_lck,
  output logic                    o_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_lck;
  logic          r_ovf;

  logic          w_full;
  logic          w_wr;
  flit_type_e    w_type;

  assign w_type = flit_type(i_din);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_wr   = i_push && (!w_full || i_pop);

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_lck   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      if (w_wr && !i_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && i_pop) r_count <= r_count - 1'b1;
      if (i_push && !w_wr) r_ovf <= 1'b1;
      if (w_wr && w_type == FT_HEAD)      r_lck <= 1'b1;
      else if (w_wr && w_type == FT_TAIL) r_lck <= 1'b0;
    end
  end

  // Storage is not reset: stale entries are unreachable once the count clears.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_count;
  assign o_rdy   = (r_count <= CW'(DEPTH - 2));
  assign o_lck   = r_lck;
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/outputc.sv
// Transmit side of a physical channel: per-VC buffers, round-robin pop gated by downstream irdy, registered link.
// ivalid-to-ovalid is 2 cycles minimum; one flit per cycle across all VCs.
module outputc
  import outputc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [`DATAW:0]    idata,
  input  logic               ivalid,
  input  logic [`VCHW:0]     ivch,
  output logic [`VCH:0]      ordy,
  output logic [`VCH:0]      olck,
  output logic [`DATAW:0]    odata,
  output logic               ovalid,
  output logic [`VCHW:0]     ovch,
  input  logic [`VCH:0]      irdy,
  output logic               ovf
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               w_wr;
  logic [NVC-1:0]     w_push;
  logic [NVC-1:0]     w_pop;
  logic [NVC-1:0]     w_elig;
  logic [NVC-1:0]     w_ovf;
  logic [DW-1:0]      w_dout  [NVC];
  logic [CW-1:0]      w_count [NVC];

  logic               w_gnt;
  logic [VCW-1:0]     w_gnt_vc;
  logic [VCW-1:0]     w_idx;

  logic [VCW-1:0]     r_rr;
  logic [DW-1:0]      r_odata;
  logic               r_ovalid;
  logic [VCW-1:0]     r_ovch;

  assign w_wr = ivalid && (flit_type(idata) != FT_NONE);

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    assign w_push[v] = w_wr && (int'(ivch) == v);
    assign w_elig[v] = (w_count[v] != '0) && irdy[v];

    outc_vcbuf #(.DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .rst_    (rst_),
      .i_push  (w_push[v]),
      .i_pop   (w_pop[v]),
      .i_din   (idata),
      .o_dout  (w_dout[v]),
      .o_count (w_count[v]),
      .o_rdy   (ordy[v]),
      .o_lck   (olck[v]),
      .o_ovf   (w_ovf[v])
    );
  end

  // Scan VCs cyclically from r_rr; the first eligible one wins.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_vc = r_rr;
    w_idx    = r_rr;
    for (int i = 0; i < NVC; i++) begin
      if (!w_gnt && w_elig[w_idx]) begin
        w_gnt    = 1'b1;
        w_gnt_vc = w_idx;
      end
      w_idx = vc_inc(w_idx);
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_gnt) w_pop[w_gnt_vc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_rr     <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_ovch   <= '0;
    end else begin
      r_ovalid <= w_gnt;
      r_odata  <= w_gnt ? w_dout[w_gnt_vc] : '0;
      if (w_gnt) begin
        r_ovch <= w_gnt_vc;
        r_rr   <= vc_inc(w_gnt_vc);
      end
    end
  end

  assign odata  = r_odata;
  assign ovalid = r_ovalid;
  assign ovch   = r_ovch;
  assign ovf    = |w_ovf;

`ifndef SYNTHESIS
  a_head_on_locked_vc: assert property (@(posedge clk) disable iff (rst_)
      !(w_wr && flit_type(idata) == FT_HEAD && olck[ivch]))
    else $error("outputc r%0d p%0d: HEAD written to locked VC %0d", ROUTERID, PCHID, ivch);
`endif
endmodule

// File: tb/tb_outputc.sv
// Directed bench for outputc: table of per-cycle vectors plus a back-to-back streaming sequence.
module tb_outputc;
  import outputc_pkg::*;

  localparam int PLW = DW - TW;

  logic           clk = 1'b0;
  logic           rst_ = 1'b1;
  logic [DW-1:0]  idata = '0;
  logic           ivalid = 1'b0;
  logic [VCW-1:0] ivch = '0;
  logic [NVC-1:0] ordy, olck;
  logic [DW-1:0]  odata;
  logic           ovalid;
  logic [VCW-1:0] ovch;
  logic [NVC-1:0] irdy = '1;
  logic           ovf;

  int errs = 0;
  int checks = 0;

  outputc #(.ROUTERID(0), .PCHID(0), .DEPTH(4)) u_dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ordy(ordy), .olck(olck), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .irdy(irdy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           iv;
    logic [VCW-1:0] vc;
    logic [DW-1:0]  d;
    logic [NVC-1:0] rdy;
    logic [NVC-1:0] e_ordy;
    logic [NVC-1:0] e_olck;
    logic           e_ovalid;
    logic [VCW-1:0] e_ovch;
    logic [DW-1:0]  e_odata;
    logic           e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] fl(input flit_type_e t, input int p);
    return {t, PLW'(p)};
  endfunction

  task automatic add(input logic r, input logic iv, input logic [VCW-1:0] vc,
                     input logic [DW-1:0] d, input logic [NVC-1:0] rdy,
                     input logic [NVC-1:0] e_ordy, input logic [NVC-1:0] e_olck,
                     input logic e_ov, input logic [VCW-1:0] e_ch,
                     input logic [DW-1:0] e_d, input logic e_ovf);
    vec_t v;
    v.rst = r; v.iv = iv; v.vc = vc; v.d = d; v.rdy = rdy;
    v.e_ordy = e_ordy; v.e_olck = e_olck; v.e_ovalid = e_ov;
    v.e_ovch = e_ch; v.e_odata = e_d; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  logic [DW-1:0]  exp_d[$];
  logic [VCW-1:0] exp_c[$];
  int             got_n;

  task automatic consume();
    if (ovalid) begin
      if (exp_d.size() == 0) begin
        checks++; errs++;
        $display("FAIL stream_unexpected: got flit %h on vc %0d, expected none", odata, ovch);
      end else begin
        check($sformatf("stream%0d_odata", got_n), odata, exp_d.pop_front());
        check($sformatf("stream%0d_ovch", got_n), DW'(ovch), DW'(exp_c.pop_front()));
        got_n++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst iv vc data                      irdy   ordy   olck   ov ch odata                    ovf
    add(1, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(1, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    // single HEADTAIL on VC0
    add(0, 1, 0, fl(FT_HEADTAIL, 'h11),     2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 0, fl(FT_HEADTAIL, 'h11),   0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    // 3-flit packet held on VC1, then released
    add(0, 1, 1, fl(FT_HEAD, 'h21),         2'b01, 2'b11, 2'b10, 0, 0, '0,                      0);
    add(0, 1, 1, fl(FT_BODY, 'h22),         2'b01, 2'b11, 2'b10, 0, 0, '0,                      0);
    add(0, 1, 1, fl(FT_TAIL, 'h23),         2'b01, 2'b01, 2'b00, 0, 0, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 1, fl(FT_HEAD, 'h21),       0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 1, fl(FT_BODY, 'h22),       0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 1, fl(FT_TAIL, 'h23),       0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 1, '0,                      0);
    // two flits per VC, round-robin from VC0, then irdy[0] drops
    add(0, 1, 0, fl(FT_HEADTAIL, 'h31),     2'b00, 2'b11, 2'b00, 0, 1, '0,                      0);
    add(0, 1, 1, fl(FT_HEADTAIL, 'h41),     2'b00, 2'b11, 2'b00, 0, 1, '0,                      0);
    add(0, 1, 0, fl(FT_HEADTAIL, 'h32),     2'b00, 2'b11, 2'b00, 0, 1, '0,                      0);
    add(0, 1, 1, fl(FT_HEADTAIL, 'h42),     2'b00, 2'b11, 2'b00, 0, 1, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 0, fl(FT_HEADTAIL, 'h31),   0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 1, fl(FT_HEADTAIL, 'h41),   0);
    add(0, 0, 0, '0,                        2'b10, 2'b11, 2'b00, 1, 1, fl(FT_HEADTAIL, 'h42),   0);
    add(0, 0, 0, '0,                        2'b10, 2'b11, 2'b00, 0, 1, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 1, 0, fl(FT_HEADTAIL, 'h32),   0);
    // fill VC0, fifth write overflows, reset clears
    add(0, 1, 0, fl(FT_BODY, 'h51),         2'b00, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 0, fl(FT_BODY, 'h52),         2'b00, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 0, fl(FT_BODY, 'h53),         2'b00, 2'b10, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 0, fl(FT_BODY, 'h54),         2'b00, 2'b10, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 0, fl(FT_BODY, 'h55),         2'b00, 2'b10, 2'b00, 0, 0, '0,                      1);
    add(0, 0, 0, '0,                        2'b00, 2'b10, 2'b00, 0, 0, '0,                      1);
    add(1, 0, 0, '0,                        2'b00, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    // reset in the middle of a locked packet
    add(0, 1, 0, fl(FT_HEAD, 'h61),         2'b00, 2'b11, 2'b01, 0, 0, '0,                      0);
    add(1, 0, 0, '0,                        2'b00, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 0, 0, '0,                        2'b11, 2'b11, 2'b00, 0, 0, '0,                      0);
    // full VC1 accepts a write in the same cycle it pops
    add(0, 1, 1, fl(FT_BODY, 'h71),         2'b00, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 1, fl(FT_BODY, 'h72),         2'b00, 2'b11, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 1, fl(FT_BODY, 'h73),         2'b00, 2'b01, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 1, fl(FT_BODY, 'h74),         2'b00, 2'b01, 2'b00, 0, 0, '0,                      0);
    add(0, 1, 1, fl(FT_BODY, 'h75),         2'b10, 2'b01, 2'b00, 1, 1, fl(FT_BODY, 'h71),       0);
    add(0, 0, 0, '0,                        2'b10, 2'b01, 2'b00, 1, 1, fl(FT_BODY, 'h72),       0);
    add(0, 0, 0, '0,                        2'b10, 2'b11, 2'b00, 1, 1, fl(FT_BODY, 'h73),       0);
    add(0, 0, 0, '0,                        2'b10, 2'b11, 2'b00, 1, 1, fl(FT_BODY, 'h74),       0);
    add(0, 0, 0, '0,                        2'b10, 2'b11, 2'b00, 1, 1, fl(FT_BODY, 'h75),       0);
    add(0, 0, 0, '0,                        2'b10, 2'b11, 2'b00, 0, 1, '0,                      0);

    for (int k = 0; k < vecs.size(); k++) begin
      rst_   = vecs[k].rst;
      ivalid = vecs[k].iv;
      ivch   = vecs[k].vc;
      idata  = vecs[k].d;
      irdy   = vecs[k].rdy;
      @(posedge clk); #1;
      check($sformatf("v%0d_ordy", k),   DW'(ordy),   DW'(vecs[k].e_ordy));
      check($sformatf("v%0d_olck", k),   DW'(olck),   DW'(vecs[k].e_olck));
      check($sformatf("v%0d_ovalid", k), DW'(ovalid), DW'(vecs[k].e_ovalid));
      check($sformatf("v%0d_ovch", k),   DW'(ovch),   DW'(vecs[k].e_ovch));
      check($sformatf("v%0d_odata", k),  odata,       vecs[k].e_odata);
      check($sformatf("v%0d_ovf", k),    DW'(ovf),    DW'(vecs[k].e_ovf));
    end

    // Back-to-back writes alternating VCs: each flit leaves one step after its write, no gaps.
    got_n = 0;
    for (int i = 0; i < 6; i++) begin
      rst_   = 1'b0;
      ivalid = 1'b1;
      ivch   = VCW'(i % 2);
      idata  = fl(FT_HEADTAIL, 'h80 + i);
      irdy   = '1;
      exp_d.push_back(idata);
      exp_c.push_back(ivch);
      @(posedge clk); #1;
      check($sformatf("stream_step%0d_ovalid", i), DW'(ovalid), DW'(i > 0));
      consume();
    end
    ivalid = 1'b0;
    idata  = '0;
    for (int t = 0; t < 10 && got_n < 6; t++) begin
      @(posedge clk); #1;
      consume();
    end
    check("stream_received_count", DW'(got_n), DW'(6));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
